// File: rtl/i2c_slave_core.sv
// Bit-level I2C target: oversamples SCL/SDA, detects START/STOP, matches a 7-bit
// address and shifts data bytes in or out over a simple parallel handshake.
module i2c_slave_core #(
    parameter int ADDR_W = 7,
    parameter int DWIDTH = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Scl_i,
    input  logic              Sda_i,
    output logic              Sda_oe,
    input  logic [ADDR_W-1:0] Slave_addr,
    input  logic              Rx_nack,
    output logic [DWIDTH-1:0] Rx_data,
    output logic              Rx_valid,
    input  logic [DWIDTH-1:0] Tx_data,
    output logic              Tx_rd,
    output logic              Rw,
    output logic              Addr_match,
    output logic              Busy,
    output logic              Stop_det
);

    localparam int CNT_W = $clog2(DWIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE
    } state_t;

    state_t            state_q;
    logic [1:0]        sclSync_q, sdaSync_q;
    logic              sclPrev_q, sdaPrev_q;
    logic [DWIDTH-1:0] shift_q;
    logic [CNT_W-1:0]  bitCnt_q;
    logic              byteDone_q;
    logic              rxPend_q;
    logic              ackIn_q;
    logic              sdaOe_q, rxValid_q, txRd_q, rw_q, addrMatch_q, busy_q, stopDet_q;
    logic [DWIDTH-1:0] rxData_q;

    logic scl, sda, sclRise, sclFall, startEv, stopEv, addrHit;

    assign scl     = sclSync_q[1];
    assign sda     = sdaSync_q[1];
    assign sclRise = scl & ~sclPrev_q;
    assign sclFall = ~scl & sclPrev_q;
    assign startEv = ~sda & sdaPrev_q & scl & sclPrev_q;
    assign stopEv  = sda & ~sdaPrev_q & scl & sclPrev_q;
    assign addrHit = (shift_q[ADDR_W:1] == Slave_addr);

    // byteDone_q marks that all bits of the byte were sampled, so the next SCL
    // fall is the byte-end fall rather than the fall right after START.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            sclSync_q   <= 2'b11;
            sdaSync_q   <= 2'b11;
            sclPrev_q   <= 1'b1;
            sdaPrev_q   <= 1'b1;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            byteDone_q  <= 1'b0;
            rxPend_q    <= 1'b0;
            ackIn_q     <= 1'b1;
            sdaOe_q     <= 1'b0;
            rxData_q    <= '0;
            rxValid_q   <= 1'b0;
            txRd_q      <= 1'b0;
            rw_q        <= 1'b0;
            addrMatch_q <= 1'b0;
            busy_q      <= 1'b0;
            stopDet_q   <= 1'b0;
        end else begin
            sclSync_q <= {sclSync_q[0], Scl_i};
            sdaSync_q <= {sdaSync_q[0], Sda_i};
            sclPrev_q <= scl;
            sdaPrev_q <= sda;
            rxValid_q <= rxPend_q;
            rxPend_q  <= 1'b0;
            txRd_q    <= 1'b0;
            stopDet_q <= 1'b0;

            if (startEv) begin
                state_q     <= ADDR;
                bitCnt_q    <= '0;
                byteDone_q  <= 1'b0;
                sdaOe_q     <= 1'b0;
                addrMatch_q <= 1'b0;
                busy_q      <= 1'b1;
            end else if (stopEv) begin
                state_q     <= IDLE;
                sdaOe_q     <= 1'b0;
                busy_q      <= 1'b0;
                addrMatch_q <= 1'b0;
                stopDet_q   <= 1'b1;
            end else if (sclRise) begin
                case (state_q)
                    ADDR, RX_DATA, TX_DATA: begin
                        if (state_q != TX_DATA)
                            shift_q <= {shift_q[DWIDTH-2:0], sda};
                        bitCnt_q <= bitCnt_q + 1'b1;
                        if (bitCnt_q == LAST_BIT) begin
                            byteDone_q <= 1'b1;
                            if (state_q == RX_DATA) begin
                                rxData_q <= {shift_q[DWIDTH-2:0], sda};
                                rxPend_q <= 1'b1;
                            end
                        end
                    end
                    TX_ACK:  ackIn_q <= sda;
                    default: ;
                endcase
            end else if (sclFall) begin
                case (state_q)
                    ADDR: if (byteDone_q) begin
                        byteDone_q <= 1'b0;
                        if (addrHit) begin
                            sdaOe_q     <= 1'b1;
                            rw_q        <= shift_q[0];
                            addrMatch_q <= 1'b1;
                            state_q     <= ADDR_ACK;
                        end else begin
                            sdaOe_q <= 1'b0;
                            state_q <= IGNORE;
                        end
                    end
                    ADDR_ACK: if (rw_q) begin
                        shift_q <= Tx_data;
                        txRd_q  <= 1'b1;
                        sdaOe_q <= ~Tx_data[DWIDTH-1];
                        state_q <= TX_DATA;
                    end else begin
                        sdaOe_q <= 1'b0;
                        state_q <= RX_DATA;
                    end
                    RX_DATA: if (byteDone_q) begin
                        byteDone_q <= 1'b0;
                        sdaOe_q    <= ~Rx_nack;
                        state_q    <= RX_ACK;
                    end
                    RX_ACK: begin
                        sdaOe_q <= 1'b0;
                        state_q <= sdaOe_q ? RX_DATA : IGNORE;
                    end
                    TX_DATA: if (byteDone_q) begin
                        byteDone_q <= 1'b0;
                        sdaOe_q    <= 1'b0;
                        state_q    <= TX_ACK;
                    end else begin
                        shift_q <= {shift_q[DWIDTH-2:0], 1'b0};
                        sdaOe_q <= ~shift_q[DWIDTH-2];
                    end
                    TX_ACK: if (!ackIn_q) begin
                        shift_q <= Tx_data;
                        txRd_q  <= 1'b1;
                        sdaOe_q <= ~Tx_data[DWIDTH-1];
                        state_q <= TX_DATA;
                    end else begin
                        sdaOe_q <= 1'b0;
                        state_q <= IGNORE;
                    end
                    default: sdaOe_q <= 1'b0;
                endcase
            end
        end
    end

    assign Sda_oe     = sdaOe_q;
    assign Rx_data    = rxData_q;
    assign Rx_valid   = rxValid_q;
    assign Tx_rd      = txRd_q;
    assign Rw         = rw_q;
    assign Addr_match = addrMatch_q;
    assign Busy       = busy_q;
    assign Stop_det   = stopDet_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: a bit-banged I2C master drives the open-drain bus and a
// scoreboard of expected received/transmitted bytes is checked as the target responds.
`timescale 1ns/1ps
module tb_i2c_slave_core;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       masterScl, masterSda;
    logic       sdaBus;
    logic       Sda_oe;
    logic [6:0] Slave_addr;
    logic       Rx_nack;
    logic [7:0] Rx_data;
    logic       Rx_valid;
    logic [7:0] Tx_data;
    logic       Tx_rd, Rw, Addr_match, Busy, Stop_det;

    int checks = 0;
    int failures = 0;
    int rxCount = 0;
    int txRdCount = 0;
    int stopCount = 0;
    int oeCount = 0;
    logic [7:0] rxQ[$];
    logic [7:0] txQ[$];

    assign sdaBus = masterSda & ~Sda_oe;

    i2c_slave_core #(.ADDR_W(7), .DWIDTH(8)) dut (
        .Clk(Clk), .Rst(Rst), .Scl_i(masterScl), .Sda_i(sdaBus), .Sda_oe(Sda_oe),
        .Slave_addr(Slave_addr), .Rx_nack(Rx_nack), .Rx_data(Rx_data), .Rx_valid(Rx_valid),
        .Tx_data(Tx_data), .Tx_rd(Tx_rd), .Rw(Rw), .Addr_match(Addr_match), .Busy(Busy),
        .Stop_det(Stop_det)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Output monitors sample on the falling clock edge, away from DUT updates.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (Sda_oe) oeCount++;
            if (Tx_rd) txRdCount++;
            if (Stop_det) stopCount++;
            if (Rx_valid) begin
                rxCount++;
                if (rxQ.size() == 0) checkOutput("rxUnexpected", 32'd1, 32'd0);
                else checkOutput("rxData", {24'd0, Rx_data}, {24'd0, rxQ.pop_front()});
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic clockBit(input logic b, output logic sampled);
        masterSda = b;
        waitClk(4);
        masterScl = 1'b1;
        waitClk(4);
        sampled = sdaBus;
        waitClk(4);
        masterScl = 1'b0;
        waitClk(4);
    endtask

    task automatic startCond();
        masterSda = 1'b1;
        waitClk(4);
        masterScl = 1'b1;
        waitClk(8);
        masterSda = 1'b0;
        waitClk(8);
        masterScl = 1'b0;
        waitClk(4);
    endtask

    task automatic stopCond();
        masterSda = 1'b0;
        waitClk(4);
        masterScl = 1'b1;
        waitClk(8);
        masterSda = 1'b1;
        waitClk(8);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clockBit(b[i], s);
        clockBit(1'b1, s);
        acked = ~s;
    endtask

    task automatic readByte(input logic ackIt, output logic [7:0] b);
        logic s;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            clockBit(1'b1, s);
            b = {b[6:0], s};
        end
        clockBit(~ackIt, s);
    endtask

    task automatic checkTx(input string tag, input logic [7:0] got);
        if (txQ.size() == 0) checkOutput({tag, "_empty"}, 32'd1, 32'd0);
        else checkOutput(tag, {24'd0, got}, {24'd0, txQ.pop_front()});
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] b;
        int         waited;

        Rst = 1'b1;
        masterScl = 1'b1;
        masterSda = 1'b1;
        Slave_addr = 7'h50;
        Rx_nack = 1'b0;
        Tx_data = 8'h00;
        waitClk(4);
        checkOutput("rstOe", {31'd0, Sda_oe}, 32'd0);
        checkOutput("rstBusy", {31'd0, Busy}, 32'd0);
        checkOutput("rstMatch", {31'd0, Addr_match}, 32'd0);
        checkOutput("rstRxData", {24'd0, Rx_data}, 32'd0);
        checkOutput("rstFlags", {28'd0, Rx_valid, Tx_rd, Rw, Stop_det}, 32'd0);
        Rst = 1'b0;
        waitClk(6);

        // Plain write of one data byte.
        $display("[TB] write 0xA5 to 0x50");
        rxCount = 0; stopCount = 0;
        startCond();
        checkOutput("t1Busy", {31'd0, Busy}, 32'd1);
        writeByte(8'hA0, ack);
        checkOutput("t1AddrAck", {31'd0, ack}, 32'd1);
        checkOutput("t1Rw", {31'd0, Rw}, 32'd0);
        checkOutput("t1Match", {31'd0, Addr_match}, 32'd1);
        rxQ.push_back(8'hA5);
        writeByte(8'hA5, ack);
        checkOutput("t1DataAck", {31'd0, ack}, 32'd1);
        stopCond();
        checkOutput("t1RxCount", rxCount, 32'd1);
        checkOutput("t1StopCount", stopCount, 32'd1);
        checkOutput("t1BusyEnd", {31'd0, Busy}, 32'd0);
        checkOutput("t1MatchEnd", {31'd0, Addr_match}, 32'd0);

        // Wrong address: never ACKed.
        $display("[TB] write to foreign address 0x51");
        rxCount = 0; oeCount = 0;
        startCond();
        writeByte(8'hA2, ack);
        checkOutput("t2AddrAck", {31'd0, ack}, 32'd0);
        writeByte(8'hFF, ack);
        checkOutput("t2DataAck", {31'd0, ack}, 32'd0);
        checkOutput("t2OeCount", oeCount, 32'd0);
        checkOutput("t2RxCount", rxCount, 32'd0);
        checkOutput("t2Match", {31'd0, Addr_match}, 32'd0);
        stopCond();

        // Read two bytes from 0x3C, NACK the last.
        $display("[TB] read two bytes from 0x3C");
        Slave_addr = 7'h3C;
        txRdCount = 0;
        Tx_data = 8'h96;
        txQ.push_back(8'h96);
        startCond();
        writeByte(8'h79, ack);
        checkOutput("t3AddrAck", {31'd0, ack}, 32'd1);
        checkOutput("t3Rw", {31'd0, Rw}, 32'd1);
        Tx_data = 8'h5A;
        txQ.push_back(8'h5A);
        readByte(1'b1, b);
        checkTx("t3Byte0", b);
        readByte(1'b0, b);
        checkTx("t3Byte1", b);
        checkOutput("t3OeReleased", {31'd0, Sda_oe}, 32'd0);
        checkOutput("t3TxRdCount", txRdCount, 32'd2);
        stopCond();
        checkOutput("t3BusyEnd", {31'd0, Busy}, 32'd0);

        // Rx_nack on the second byte of a write.
        $display("[TB] write with NACK on second byte");
        Slave_addr = 7'h50;
        rxCount = 0;
        startCond();
        writeByte(8'hA0, ack);
        checkOutput("t4AddrAck", {31'd0, ack}, 32'd1);
        rxQ.push_back(8'h11);
        writeByte(8'h11, ack);
        checkOutput("t4Byte0Ack", {31'd0, ack}, 32'd1);
        Rx_nack = 1'b1;
        rxQ.push_back(8'h22);
        writeByte(8'h22, ack);
        checkOutput("t4Byte1Ack", {31'd0, ack}, 32'd0);
        Rx_nack = 1'b0;
        writeByte(8'h33, ack);
        checkOutput("t4Byte2Ack", {31'd0, ack}, 32'd0);
        stopCond();
        checkOutput("t4RxCount", rxCount, 32'd2);

        // Repeated START in the middle of a data byte, then a read.
        $display("[TB] repeated START mid-byte");
        rxCount = 0;
        startCond();
        writeByte(8'hA0, ack);
        checkOutput("t5AddrAck", {31'd0, ack}, 32'd1);
        for (int i = 0; i < 4; i++) clockBit(i[0], s);
        startCond();
        checkOutput("t5MatchCleared", {31'd0, Addr_match}, 32'd0);
        Tx_data = 8'hC3;
        txQ.push_back(8'hC3);
        writeByte(8'hA1, ack);
        checkOutput("t5ReadAck", {31'd0, ack}, 32'd1);
        checkOutput("t5Rw", {31'd0, Rw}, 32'd1);
        readByte(1'b0, b);
        checkTx("t5Byte", b);
        stopCond();
        checkOutput("t5RxCount", rxCount, 32'd0);

        // Reset while the target is driving an ACK.
        $display("[TB] reset during ACK slot");
        rxCount = 0;
        startCond();
        for (int i = 7; i >= 0; i--) clockBit(1'(8'hA0 >> i), s);
        masterSda = 1'b1;
        waited = 0;
        while (!Sda_oe && waited < 20) begin
            waitClk(1);
            waited++;
        end
        checkOutput("t6OeBeforeRst", {31'd0, Sda_oe}, 32'd1);
        Rst = 1'b1;
        waitClk(1);
        checkOutput("t6RstOe", {31'd0, Sda_oe}, 32'd0);
        checkOutput("t6RstBusy", {31'd0, Busy}, 32'd0);
        checkOutput("t6RstMatch", {31'd0, Addr_match}, 32'd0);
        checkOutput("t6RstRest", {20'd0, Rx_data, Rx_valid, Tx_rd, Rw, Stop_det}, 32'd0);
        Rst = 1'b0;
        oeCount = 0;
        waitClk(4);
        masterScl = 1'b1;
        waitClk(8);
        masterScl = 1'b0;
        waitClk(4);
        writeByte(8'h55, ack);
        checkOutput("t6NoResponse", oeCount, 32'd0);
        checkOutput("t6IdleBusy", {31'd0, Busy}, 32'd0);
        stopCond();
        startCond();
        writeByte(8'hA0, ack);
        checkOutput("t6FreshAddrAck", {31'd0, ack}, 32'd1);
        rxQ.push_back(8'h77);
        writeByte(8'h77, ack);
        checkOutput("t6FreshDataAck", {31'd0, ack}, 32'd1);
        stopCond();
        checkOutput("t6RxCount", rxCount, 32'd1);

        waitClk(4);
        checkOutput("rxQEmpty", rxQ.size(), 32'd0);
        checkOutput("txQEmpty", txQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
